muldiv_seq: RTL

//  Iterative RV32M multiply/divide sequencer: a controller that drives the shared ALU.

---
 rtl/rv32i_defs.sv | 38 +++
 rtl/alu.sv | 40 ++++
 rtl/muldiv_sign_unit.sv | 33 +++
 rtl/muldiv_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_defs.sv
// Shared RV32I definitions: ALU opcodes plus the multiply/divide sequencer types.
package rv32i_defs;

  localparam int MULDIV_ITERS = 32;

  typedef enum logic [3:0] {
    SUM = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    XOR = 4'd4
  } alu_opcode_t;

  // funct3 encoding of the M extension
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } muldiv_state_t;

  function automatic logic is_div_op(input muldiv_op_t o);
    return o[2];
  endfunction

endpackage

// File: rtl/alu.sv
// Shared combinational ALU; status = {n, z, c, v}, c is carry-out on SUM and no-borrow on SUB.
module alu
  import rv32i_defs::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_opcode_t     operation,
  output logic [XLEN-1:0] result,
  output logic [3:0]      status
);

  localparam logic [XLEN:0] ONE = 1;

  logic [XLEN:0] wide;
  logic          ovf;

  always_comb begin
    wide = '0;
    ovf  = 1'b0;
    case (operation)
      SUM: begin
        wide = {1'b0, a} + {1'b0, b};
        ovf  = (a[XLEN-1] == b[XLEN-1]) && (wide[XLEN-1] != a[XLEN-1]);
      end
      SUB: begin
        wide = {1'b0, a} + {1'b0, ~b} + ONE;
        ovf  = (a[XLEN-1] != b[XLEN-1]) && (wide[XLEN-1] != a[XLEN-1]);
      end
      AND:     wide = {1'b0, a & b};
      OR:      wide = {1'b0, a | b};
      XOR:     wide = {1'b0, a ^ b};
      default: wide = '0;
    endcase
    result = wide[XLEN-1:0];
    status = {wide[XLEN-1], (wide[XLEN-1:0] == '0), wide[XLEN], ovf};
  end

endmodule

// File: rtl/muldiv_sign_unit.sv
// Operand magnitudes (PREP) and result negation (FIX) for the multiply/divide sequencer.
module muldiv_sign_unit #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            a_signed,
  input  logic            b_signed,
  output logic [XLEN-1:0] a_mag,
  output logic [XLEN-1:0] b_mag,
  output logic            a_neg,
  output logic            b_neg,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] hi_neg,
  output logic [XLEN-1:0] lo_neg,
  output logic [XLEN-1:0] hi_neg_wide
);

  localparam logic [XLEN-1:0] ONE  = 1;
  localparam logic [XLEN-1:0] ZERO = 0;

  assign a_neg = a_signed & a[XLEN-1];
  assign b_neg = b_signed & b[XLEN-1];
  assign a_mag = a_neg ? (~a + ONE) : a;
  assign b_mag = b_neg ? (~b + ONE) : b;

  assign lo_neg = ~lo + ONE;
  assign hi_neg = ~hi + ONE;
  // Upper half of the 2*XLEN negation: the +1 only ripples in when lo is all zeros
  assign hi_neg_wide = ~hi + ((lo == ZERO) ? ONE : ZERO);

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer driving the shared ALU.
// RVSCC_DIV_EN enables the DIV/DIVU/REM/REMU datapath; otherwise div ops complete early with 0.
module muldiv_seq
  import rv32i_defs::*;
#(
  parameter int XLEN = MULDIV_ITERS
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output alu_opcode_t     alu_operation,
  input  logic [XLEN-1:0] alu_result,
  input  logic [3:0]      alu_status,
  output logic [2:0]      dbg_state
);

  localparam int              CW   = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q, state_d;
  muldiv_op_t      op_q;
  logic [XLEN-1:0] hi, lo, dvs;
  logic [CW-1:0]   cnt;
  logic            neg_prod_q, neg_rem_q;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, hi_neg, lo_neg, hi_neg_wide;
  logic            special;
  logic [XLEN-1:0] special_result, fix_result;
  logic            unused_status;

  assign unused_status = &{1'b0, alu_status[3:2], alu_status[0]};
  assign dbg_state     = state_q;

  assign a_signed = (op_q == MULH) || (op_q == MULHSU) || (op_q == DIV) || (op_q == REM);
  assign b_signed = (op_q == MULH) || (op_q == DIV) || (op_q == REM);

  // In PREP, lo/dvs still hold the raw rs1/rs2 captured at the accepting edge
  muldiv_sign_unit #(.XLEN(XLEN)) u_sign (
    .a          (lo),
    .b          (dvs),
    .a_signed   (a_signed),
    .b_signed   (b_signed),
    .a_mag      (a_mag),
    .b_mag      (b_mag),
    .a_neg      (a_neg),
    .b_neg      (b_neg),
    .hi         (hi),
    .lo         (lo),
    .hi_neg     (hi_neg),
    .lo_neg     (lo_neg),
    .hi_neg_wide(hi_neg_wide)
  );

`ifdef RVSCC_DIV_EN
  logic [XLEN-1:0] rem_sh;
  logic            div_zero, div_ovf;

  assign rem_sh   = {hi[XLEN-2:0], lo[XLEN-1]};
  assign div_zero = is_div_op(op_q) && (dvs == '0);
  assign div_ovf  = ((op_q == DIV) || (op_q == REM)) && (lo == SMIN) && (dvs == '1);

  always_comb begin
    special        = div_zero || div_ovf;
    special_result = '0;
    if (div_zero)
      special_result = ((op_q == DIV) || (op_q == DIVU)) ? '1 : lo;
    else if (div_ovf)
      special_result = (op_q == DIV) ? SMIN : '0;
  end
`else
  always_comb begin
    special        = is_div_op(op_q);
    special_result = '0;
  end
`endif

  always_comb begin
    case (op_q)
      MUL, DIV, DIVU:      fix_result = neg_prod_q ? lo_neg : lo;
      MULH, MULHSU, MULHU: fix_result = neg_prod_q ? hi_neg_wide : hi;
      REM, REMU:           fix_result = neg_rem_q ? hi_neg : hi;
      default:             fix_result = lo;
    endcase
  end

  // FSM next state and status outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = PREP;
      PREP: begin
        busy    = 1'b1;
        state_d = special ? DONE : ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (cnt == LAST) state_d = FIX;
      end
      FIX: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU is only borrowed during ITER; elsewhere it sees SUM(0,0)
  always_comb begin
    alu_a         = '0;
    alu_b         = '0;
    alu_operation = SUM;
    if (state_q == ITER) begin
      alu_a = hi;
      alu_b = dvs;
`ifdef RVSCC_DIV_EN
      if (is_div_op(op_q)) begin
        alu_a         = rem_sh;
        alu_operation = SUB;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q       <= MUL;
      hi         <= '0;
      lo         <= '0;
      dvs        <= '0;
      cnt        <= '0;
      neg_prod_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q <= muldiv_op_t'(op);
            lo   <= rs1;
            dvs  <= rs2;
          end
        end
        PREP: begin
          hi         <= '0;
          lo         <= a_mag;
          dvs        <= b_mag;
          cnt        <= '0;
          neg_prod_q <= a_neg ^ b_neg;
          neg_rem_q  <= a_neg;
          if (special) result <= special_result;
        end
        ITER: begin
          cnt <= cnt + CW'(1);
`ifdef RVSCC_DIV_EN
          if (is_div_op(op_q)) begin
            // Commit when the 33-bit partial remainder covers the divisor
            if (alu_status[1] || hi[XLEN-1]) begin
              hi <= alu_result;
              lo <= {lo[XLEN-2:0], 1'b1};
            end else begin
              hi <= rem_sh;
              lo <= {lo[XLEN-2:0], 1'b0};
            end
          end else
`endif
          if (lo[0]) begin
            hi <= {alu_status[1], alu_result[XLEN-1:1]};
            lo <= {alu_result[0], lo[XLEN-1:1]};
          end else begin
            hi <= {1'b0, hi[XLEN-1:1]};
            lo <= {hi[0], lo[XLEN-1:1]};
          end
        end
        FIX:     result <= fix_result;
        default: ;
      endcase
    end
  end

endmodule
